// File: rtl/instruction_encoder_if.sv
// Bus bundle between the control-word source, the instruction encoder and the
// instruction memory write port.
interface instruction_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              cw_valid;
    logic [19:0]       cw;
    logic              cw_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [7:0]        err_count;

    modport slave (
        input  start, base_addr, word_count, cw_valid, cw, mem_ready,
        output cw_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_count
    );

    modport master (
        output start, base_addr, word_count, cw_valid, cw, mem_ready,
        input  cw_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_count
    );
endinterface

// File: rtl/instruction_encoder.sv
// Converts 20-bit microcode control words into 16-bit instruction words and
// streams them into instruction memory, rejecting illegal control words.
module instruction_encoder #(
    parameter int ADDR_W = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    instruction_encoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [7:0]        errcnt_q, errcnt_d;
    logic              done_q, done_d;

    logic [15:0] enc;
    logic        legal;
    logic        cw_ready_c;
    logic        accept;
    logic        complete;

    function automatic logic [15:0] encode(input logic [19:0] c);
        logic [15:0] ir;
        ir[8:6] = c[19:17];
        ir[5:3] = c[16:14];
        ir[2:0] = c[13:11];
        ir[15]  = c[10];
        ir[14]  = ~c[4];
        ir[13]  = c[5];
        ir[12]  = c[9];
        ir[11]  = c[8];
        ir[10]  = c[7];
        ir[9]   = c[0];
        return ir;
    endfunction

    // Bits 6,3,2,1 are redundant with the encoded fields; any disagreement marks a corrupt word.
    function automatic logic is_legal(input logic [19:0] c);
        logic ir14, ir15;
        ir14 = ~c[4];
        ir15 = c[10];
        return (c[3] == (ir14 & ~ir15)) && (c[2] == (ir14 & ir15)) &&
               (c[1] == c[5]) && (c[6] == (c[0] & ~c[2]));
    endfunction

    always_comb begin
        enc        = encode(bus.cw);
        legal      = is_legal(bus.cw);
        cw_ready_c = (state_q == RUN) && (rem_q != '0) && (!we_q || bus.mem_ready);
        accept     = bus.cw_valid && cw_ready_c;
        complete   = we_q && bus.mem_ready;

        state_d  = state_q;
        rem_d    = rem_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        err_d    = err_q;
        errcnt_d = errcnt_q;
        done_d   = 1'b0;

        if (complete) begin
            we_d   = 1'b0;
            addr_d = addr_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.word_count != '0) begin
                        state_d  = RUN;
                        rem_d    = bus.word_count;
                        addr_d   = bus.base_addr;
                        err_d    = 1'b0;
                        errcnt_d = 8'd0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (rem_q == '0) begin
                    state_d = DRAIN;
                end else if (accept) begin
                    rem_d = rem_q - 1'b1;
                    if (legal) begin
                        wdata_d = enc;
                        we_d    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                        if (errcnt_q != 8'hFF) begin
                            errcnt_d = errcnt_q + 8'd1;
                        end
                    end
                end
            end
            DRAIN: begin
                if (!we_q || complete) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            errcnt_q <= 8'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
            done_q   <= done_d;
        end
    end

    assign bus.cw_ready  = cw_ready_c;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.err_count = errcnt_q;
endmodule

// File: tb/tb_instruction_encoder.sv
// Randomized and directed bench for instruction_encoder, checked every cycle
// against a transaction-level reference model.
module tb_instruction_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    instruction_encoder_if #(.ADDR_W(8)) bus ();

    instruction_encoder #(.ADDR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: session phase 0 idle, 1 consuming, 2 flushing last write.
    int          m_state;
    int          m_rem;
    bit          m_pend;
    logic [7:0]  m_addr;
    logic [15:0] m_pdata;
    bit          m_err;
    int          m_cnt;
    bit          m_done;

    logic [23:0] wr_log[$];
    int          done_cnt;
    bit          busy_seen;
    logic [19:0] wlist[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_enc(input logic [19:0] c);
        int src[16] = '{11, 12, 13, 14, 15, 16, 17, 18, 19, 0, 7, 8, 9, 5, 4, 10};
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = c[src[i]];
        r[14] = ~c[4];
        return r;
    endfunction

    function automatic bit m_legal(input logic [19:0] c);
        logic [15:0] ir;
        ir = m_enc(c);
        return (c[3] == (ir[14] & ~ir[15])) && (c[2] == (ir[14] & ir[15])) &&
               (c[1] == c[5]) && (c[6] == (c[0] & ~c[2]));
    endfunction

    function automatic logic [19:0] gen_word(input bit make_legal);
        logic [19:0] c;
        c    = 20'($urandom);
        c[3] = ~c[4] & ~c[10];
        c[2] = ~c[4] & c[10];
        c[1] = c[5];
        c[6] = c[0] & ~c[2];
        if (!make_legal) begin
            case ($urandom_range(0, 3))
                0:       c[1] = ~c[1];
                1:       c[2] = ~c[2];
                2:       c[3] = ~c[3];
                default: c[6] = ~c[6];
            endcase
        end
        return c;
    endfunction

    task automatic model_reset();
        m_state = 0; m_rem = 0; m_pend = 0; m_addr = 8'd0;
        m_pdata = 16'd0; m_err = 0; m_cnt = 0; m_done = 0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_cw_ready", bus.cw_ready, 0);
            check("rst_mem_we", bus.mem_we, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_done", bus.done, 0);
            check("rst_err", bus.err, 0);
            check("rst_mem_addr", bus.mem_addr, 0);
            check("rst_mem_wdata", bus.mem_wdata, 0);
            check("rst_err_count", bus.err_count, 0);
            model_reset();
        end else begin
            bit exp_ready, acc, cmpl, nd;
            exp_ready = (m_state == 1) && (m_rem > 0) && (!m_pend || bus.mem_ready);
            check("cw_ready", bus.cw_ready, exp_ready);
            check("mem_we", bus.mem_we, m_pend);
            if (m_pend) begin
                check("mem_addr", bus.mem_addr, m_addr);
                check("mem_wdata", bus.mem_wdata, m_pdata);
            end
            check("busy", bus.busy, m_state != 0);
            check("done", bus.done, m_done);
            check("err", bus.err, m_err);
            check("err_count", bus.err_count, m_cnt);
            if (bus.done) done_cnt++;
            if (bus.busy) busy_seen = 1;
            if (bus.mem_we && bus.mem_ready) wr_log.push_back({bus.mem_addr, bus.mem_wdata});

            acc  = bus.cw_valid && exp_ready;
            cmpl = m_pend && bus.mem_ready;
            nd   = 0;
            if (cmpl) begin
                m_pend = 0;
                m_addr = m_addr + 8'd1;
            end
            if (m_state == 0) begin
                if (bus.start) begin
                    if (bus.word_count != 0) begin
                        m_state = 1; m_rem = int'(bus.word_count); m_addr = bus.base_addr;
                        m_err = 0; m_cnt = 0;
                    end else begin
                        nd = 1;
                    end
                end
            end else if (m_state == 1) begin
                if (m_rem == 0) m_state = 2;
                else if (acc) begin
                    m_rem--;
                    if (m_legal(bus.cw)) begin
                        m_pend = 1; m_pdata = m_enc(bus.cw);
                    end else begin
                        m_err = 1;
                        if (m_cnt < 255) m_cnt++;
                    end
                end
            end else if (!m_pend) begin
                m_state = 0; nd = 1;
            end
            m_done = nd;
        end
    end

    // mode 0: always valid/ready, 1: random with stray starts, 2: 4-cycle write stall
    task automatic session(input logic [7:0] b, input logic [8:0] wc, input int mode);
        int idx = 0;
        int stall = 4;
        bit fin = 0;
        wr_log.delete(); done_cnt = 0; busy_seen = 0;
        bus.start = 1; bus.base_addr = b; bus.word_count = wc; bus.cw_valid = 0;
        @(posedge clk); #1;
        bus.start = 0;
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            bus.cw = wlist[idx % 16];
            bus.cw_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.mem_ready = (mode == 1) ? ($urandom_range(0, 2) != 0) : (mode == 2) ? (stall == 0) : 1'b1;
            if (mode == 1 && m_state != 0 && $urandom_range(0, 7) == 0) begin
                bus.start = 1; bus.base_addr = 8'($urandom); bus.word_count = 9'($urandom_range(0, 8));
            end else begin
                bus.start = 0;
            end
            @(negedge clk);
            if (bus.cw_valid && bus.cw_ready) idx++;
            if (bus.mem_we && stall > 0) stall--;
            if (bus.done) fin = 1;
            @(posedge clk); #1;
        end
        bus.start = 0; bus.cw_valid = 0; bus.mem_ready = 1;
        if (!fin) check("session_timeout", 0, 1);
    endtask

    initial begin
        bit hit;
        bus.start = 0; bus.base_addr = 0; bus.word_count = 0;
        bus.cw_valid = 0; bus.cw = 0; bus.mem_ready = 1;
        model_reset();

        check("pin_enc", m_enc(20'hABD27), 16'hEB57);
        check("pin_legal_ok", m_legal(20'hABD27), 1);
        check("pin_legal_bad", m_legal(20'hABD25), 0);

        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) wlist[i] = 20'hABD27;
        session(8'h10, 9'd1, 0);
        check("s1_nwr", wr_log.size(), 1);
        if (wr_log.size() >= 1) check("s1_wr0", wr_log[0], 24'h10EB57);
        check("s1_done", done_cnt, 1);
        check("s1_err", bus.err, 0);

        wlist[1] = 20'hABD25;
        session(8'h20, 9'd3, 0);
        check("s2_nwr", wr_log.size(), 2);
        if (wr_log.size() >= 2) begin
            check("s2_wr0", wr_log[0], 24'h20EB57);
            check("s2_wr1", wr_log[1], 24'h21EB57);
        end
        check("s2_err", bus.err, 1);
        check("s2_errcnt", bus.err_count, 1);
        check("s2_done", done_cnt, 1);

        wlist[1] = 20'hABD27;
        session(8'h40, 9'd2, 2);
        check("s3_nwr", wr_log.size(), 2);
        if (wr_log.size() >= 2) check("s3_wr1", wr_log[1], 24'h41EB57);

        session(8'hFF, 9'd2, 0);
        check("s4_nwr", wr_log.size(), 2);
        if (wr_log.size() >= 2) begin
            check("s4_wr0", wr_log[0][23:16], 8'hFF);
            check("s4_wr1", wr_log[1][23:16], 8'h00);
        end

        session(8'h55, 9'd0, 0);
        check("s5_done", done_cnt, 1);
        check("s5_busy_seen", busy_seen, 0);
        check("s5_nwr", wr_log.size(), 0);

        for (int i = 0; i < 16; i++) wlist[i] = gen_word(0);
        session(8'h00, 9'd300, 0);
        check("sat_errcnt", bus.err_count, 255);
        check("sat_err", bus.err, 1);
        check("sat_nwr", wr_log.size(), 0);

        for (int s = 0; s < 20; s++) begin
            int wc;
            for (int i = 0; i < 16; i++) wlist[i] = gen_word($urandom_range(0, 3) != 0);
            wc = $urandom_range(1, 12);
            session(8'($urandom), 9'(wc), 1);
            check("rand_done", done_cnt, 1);
        end

        // Reset with a stalled write pending
        wr_log.delete(); done_cnt = 0;
        bus.start = 1; bus.base_addr = 8'h30; bus.word_count = 9'd3;
        @(posedge clk); #1;
        bus.start = 0; bus.mem_ready = 0; bus.cw_valid = 1;
        bus.cw = 20'hABD25;
        hit = 0;
        for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
            @(negedge clk);
            if (bus.mem_we) hit = 1;
            else if (bus.cw_valid && bus.cw_ready) begin
                @(posedge clk); #1;
                bus.cw = 20'hABD27;
            end else begin
                @(posedge clk); #1;
            end
        end
        check("rst_pending_seen", hit, 1);
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        check("async_mem_we", bus.mem_we, 0);
        check("async_cw_ready", bus.cw_ready, 0);
        check("async_busy", bus.busy, 0);
        check("async_err", bus.err, 0);
        check("async_err_count", bus.err_count, 0);
        check("async_mem_addr", bus.mem_addr, 0);
        check("async_mem_wdata", bus.mem_wdata, 0);
        bus.cw_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1; bus.mem_ready = 1; bus.cw_valid = 1;
        repeat (6) @(posedge clk);
        #1 bus.cw_valid = 0;
        check("rst_no_write", wr_log.size(), 0);
        check("rst_no_done", done_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
